// File: rtl/seg_pattern_rx.sv
// seg_pattern_rx: 7-segment bus receiver that debounces, decodes and pairs nibbles into bytes.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   seg_in       active-low segment bus {a,b,c,d,e,f,g}, asynchronous to clk
//   nibble_out   last decoded nibble
//   nibble_valid one-cycle pulse, nibble_out updated
//   byte_out     last assembled byte {high, low}
//   byte_valid   one-cycle pulse, byte_out updated
//   err          one-cycle pulse, stable pattern not in the code table
//   pair_lo      high nibble held, waiting for the low nibble
//   err_clr      (SEG_RX_ERR_CNT_EN only) synchronous clear of err_cnt
//   err_cnt      (SEG_RX_ERR_CNT_EN only) saturating count of err pulses
//
// Optional feature macro: SEG_RX_ERR_CNT_EN adds err_clr/err_cnt.
module seg_pattern_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
`ifdef SEG_RX_ERR_CNT_EN
    input  logic       err_clr,
    output logic [7:0] err_cnt,
`endif
    output logic [3:0] nibble_out,
    output logic       nibble_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       err,
    output logic       pair_lo
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    logic [6:0] s1, s2, prev;
    logic [CNT_W-1:0] cnt;
    logic armed, pair;
    logic [3:0] hi, dec_nib;
    logic dec_ok, blank, accept;
    // prev holds the pattern whose stable run cnt is measuring
    always_comb begin
        dec_ok = 1'b1;
        dec_nib = 4'h0;
        case (prev)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001101: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            default:    dec_ok = 1'b0;
        endcase
        blank = prev == 7'b1111111;
        accept = armed && cnt == LAST;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 7'h7f;
            s2 <= 7'h7f;
            prev <= 7'h7f;
            cnt <= '0;
            armed <= 1'b0;
            pair <= 1'b0;
            hi <= 4'h0;
            nibble_out <= 4'h0;
            nibble_valid <= 1'b0;
            byte_out <= 8'h00;
            byte_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            s1 <= seg_in;
            s2 <= s1;
            prev <= s2;
            nibble_valid <= 1'b0;
            byte_valid <= 1'b0;
            err <= 1'b0;
            if (accept) begin
                armed <= 1'b0;
                if (blank) begin
                    pair <= 1'b0;
                end else if (dec_ok) begin
                    nibble_out <= dec_nib;
                    nibble_valid <= 1'b1;
                    pair <= !pair;
                    if (pair) begin
                        byte_out <= {hi, dec_nib};
                        byte_valid <= 1'b1;
                    end else begin
                        hi <= dec_nib;
                    end
                end else begin
                    err <= 1'b1;
                    pair <= 1'b0;
                end
            end
            // a change starts a new run and re-arms, overriding the accept's disarm
            if (s2 != prev) begin
                cnt <= '0;
                armed <= 1'b1;
            end else if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    assign pair_lo = pair;
`ifdef SEG_RX_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt <= 8'h00;
        else if (err_clr) err_cnt <= 8'h00;
        else if (err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'h01;
    end
`endif
endmodule

// File: tb/tb_seg_pattern_rx.sv
// tb_seg_pattern_rx: scoreboard bench for seg_pattern_rx.
module tb_seg_pattern_rx;
    typedef struct {
        int v;
        int due;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [6:0] seg_in = 7'h7f;
    logic [3:0] nibble_out;
    logic nibble_valid, byte_valid, err, pair_lo;
    logic [7:0] byte_out;
`ifdef SEG_RX_ERR_CNT_EN
    logic err_clr = 1'b0;
    logic [7:0] err_cnt;
`endif
    int tests = 0, fails = 0, cyc = 0, ecnt = 0;
    exp_t nq[$], bq[$], eq[$];
    exp_t e;
    logic [6:0] last = 7'h7f;
    logic pair = 1'b0;
    int hi = 0;
    logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seg_pattern_rx dut (
        .clk(clk), .rst(rst), .seg_in(seg_in),
`ifdef SEG_RX_ERR_CNT_EN
        .err_clr(err_clr), .err_cnt(err_cnt),
`endif
        .nibble_out(nibble_out), .nibble_valid(nibble_valid),
        .byte_out(byte_out), .byte_valid(byte_valid),
        .err(err), .pair_lo(pair_lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard pop: value and arrival cycle must match; overdue entries count as misses.
    always @(negedge clk) if (!rst) begin
        if (nibble_valid) begin
            if (nq.size() == 0) chk("nib_unexpected", nibble_out, -1);
            else begin e = nq.pop_front(); chk("nib_val", nibble_out, e.v); chk("nib_time", cyc, e.due); end
        end else if (nq.size() != 0 && nq[0].due < cyc) begin
            e = nq.pop_front(); chk("nib_missing", 0, e.v + 1);
        end
        if (byte_valid) begin
            if (bq.size() == 0) chk("byte_unexpected", byte_out, -1);
            else begin e = bq.pop_front(); chk("byte_val", byte_out, e.v); chk("byte_time", cyc, e.due); end
        end else if (bq.size() != 0 && bq[0].due < cyc) begin
            e = bq.pop_front(); chk("byte_missing", 0, e.v + 1);
        end
        if (err) begin
            if (eq.size() == 0) chk("err_unexpected", 1, 0);
            else begin e = eq.pop_front(); chk("err_time", cyc, e.due); end
        end else if (eq.size() != 0 && eq[0].due < cyc) begin
            e = eq.pop_front(); chk("err_missing", 0, 1);
        end
    end

    // Drive pattern p from a falling edge for n cycles and predict its outcome.
    task automatic put(input logic [6:0] p, input int n);
        int d;
        logic acc;
        d = -1;
        for (int i = 0; i < 16; i++) if (tbl[i] == p) d = i;
        acc = n >= 4 && p != last;
        last = p;
        seg_in = p;
        if (acc) begin
            if (p == 7'h7f) pair = 1'b0;
            else if (d >= 0) begin
                nq.push_back('{d, cyc + 7});
                if (pair) bq.push_back('{hi * 16 + d, cyc + 7});
                else hi = d;
                pair = !pair;
            end else begin
                eq.push_back('{1, cyc + 7});
                pair = 1'b0;
                if (ecnt < 255) ecnt++;
            end
        end
        repeat (n) @(negedge clk);
        if (n >= 7) chk("pair_lo", pair_lo, pair);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_nib", nibble_out, 0);
        chk("rst_byte", byte_out, 0);
        chk("rst_pulses", {nibble_valid, byte_valid, err}, 0);
        chk("rst_pair", pair_lo, 0);
        rst = 1'b0;
        put(7'h7f, 50);
        put(7'b0010010, 10);
        put(7'h7f, 10);
        put(7'b0110000, 10);
        put(7'h7f, 8);
        put(7'b1001100, 8);
        put(7'b0001000, 8);
        put(7'b0000001, 10);
        put(7'b1001111, 2);
        put(7'b0000001, 10);
        chk("glitch_nib", nibble_out, 0);
        put(7'h7f, 8);
        put(7'b0001101, 10);
        put(7'b1010101, 10);
        put(7'b0000110, 10);
        put(7'b0111000, 10);
        chk("byte_3f", byte_out, 8'h3f);
        put(7'h7f, 8);
        put(7'b0100100, 10);
        #3 rst = 1'b1;
        seg_in = 7'h7f;
        #1;
        chk("arst_nib", nibble_out, 0);
        chk("arst_byte", byte_out, 0);
        chk("arst_pair", pair_lo, 0);
        last = 7'h7f;
        pair = 1'b0;
        ecnt = 0;
        @(negedge clk);
        rst = 1'b0;
        put(7'b0000100, 10);
        put(7'b0100000, 10);
`ifdef SEG_RX_ERR_CNT_EN
        chk("ecnt_reset", err_cnt, 0);
        for (int i = 0; i < 300; i++) put(i % 2 ? 7'h2a : 7'h55, 5);
        repeat (10) @(negedge clk);
        chk("ecnt_sat", err_cnt, ecnt);
        chk("ecnt_255", err_cnt, 255);
        seg_in = 7'h55;
        last = 7'h55;
        pair = 1'b0;
        eq.push_back('{1, cyc + 7});
        for (int i = 0; i < 20 && !err; i++) @(negedge clk);
        chk("err_seen", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        ecnt = 0;
        chk("ecnt_clr_wins", err_cnt, 0);
        put(7'h7f, 8);
        put(7'b1010101, 10);
        chk("ecnt_one", err_cnt, ecnt);
`endif
        repeat (10) @(negedge clk);
        chk("sb_nib_empty", nq.size(), 0);
        chk("sb_byte_empty", bq.size(), 0);
        chk("sb_err_empty", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
